paralelo_serial_phy_tx: RTL and testbench
=========================================

# paralelo_serial_phy_tx

Transmit-side PHY serializer: accepts bytes over a valid/ready handshake and shifts them out MSB-first on a single serial line, one bit per `clk_32f` cycle. After reset it sends `SYNC_WORDS` comma words (0xBC) so the far-end serial-to-parallel receiver can reach its active state. When no byte is pending at a word boundary, it fills the line with commas. It sits between the parallel datapath and the serial link, opposite the phy_rx serial-to-parallel block.

## Interface
- `COMMA`, 8'hBC, idle/sync word.
- `SYNC_WORDS`, 4, number of commas sent after reset before data is allowed on the line; must be ≥1.
- `clk_32f`  input  1  serial bit clock; all state updates on its rising edge.
- `reset_L`  input  1  reset, asynchronous assert, active-low.
- `data_in`  input  8  byte to transmit.
- `valid_in`  input  1  `data_in` is valid.
- `ready_out`  output  1  holding register empty; a byte is accepted on an edge where `valid_in && ready_out`.
- `data_out`  output  1  serial line, MSB first.
- `active`  output  1  high once sync is complete and the line may carry data.

## Operation
- State: `shreg[7:0]`, `bit_cnt[2:0]`, `sync_cnt` ($clog2(SYNC_WORDS+1) bits), `state ∈ {SYNC, ACTIVE}`, `hold_data[7:0]`, `hold_full`.
- Reset values: `shreg`=8'h00, `bit_cnt`=7, `sync_cnt`=0, `state`=SYNC, `hold_full`=0. Outputs during reset: `data_out`=0, `ready_out`=1, `active`=0.
- Outputs:
  - `data_out` = `shreg[7]`.
  - `ready_out` = `!hold_full`.
  - `active` = (`state`==ACTIVE).
  - All three are driven directly from registers; no input-to-output combinational path.
- Each edge with `bit_cnt`≠7: `shreg` shifts left by 1 (zero fill), `bit_cnt`+1.
- Each edge with `bit_cnt`==7 (word boundary): `bit_cnt`←0, and `shreg` loads:
  - SYNC with `sync_cnt`<SYNC_WORDS: load `COMMA`, `sync_cnt`+1.
  - SYNC with `sync_cnt`==SYNC_WORDS: `state`←ACTIVE, then apply the ACTIVE rule on the same edge.
  - ACTIVE with `hold_full`: load `hold_data`, `hold_full`←0.
  - ACTIVE without `hold_full`: load `COMMA`.
- Handshake: on an edge with `valid_in && !hold_full`, `hold_data`←`data_in` and `hold_full`←1. Bytes are accepted in SYNC as well; they wait in the holding register.
- Simultaneous events: when `hold_full`=1, an accept cannot occur. A load and an accept therefore never coincide; after a load, `ready_out` reasserts on the next cycle.
- Data bytes equal to `COMMA` are sent unchanged. There is no escaping.
- Reset mid-operation: the current word is truncated, the held byte is discarded, and the full sync sequence restarts.

## Timing
- Edge n means the n-th rising edge after `reset_L` deasserts.
- Edge 1 loads the first comma. Word k (k≥0) occupies the `data_out` cycles following edges 8k+1 … 8k+8.
- Commas are words 0 … SYNC_WORDS−1. `active` rises on edge 8·SYNC_WORDS+1, which is edge 33 with default parameters.
- Latency from accept to first bit on the line: 1–8 cycles when ACTIVE; the byte waits for the next word boundary.
- Sustained throughput: one byte per 8 cycles, with no commas between bytes when `valid_in` is held high.
- `ready_out` stays low from the accept edge through the load edge, and is high again the cycle after the load.

## Structure
- Shared package `phy_pkg`: `COMMA_WORD`=8'hBC, `SYNC_WORDS_DEF`=4, state enum `tx_state_t {SYNC, ACTIVE}`. Shared with phy_rx so both ends agree on the comma and the sync count.
- One natural sub-module: `phy_tx_hold_reg`, the single-entry valid/ready holding register, exposing `full`, `data`, and a `pop` input. Shift/count/FSM logic stays in the top module.

## Test plan
- Reset released, `valid_in`=0 for 80 cycles → `data_out` repeats 1,0,1,1,1,1,0,0 starting after edge 1. `active`=0 through edge 32 and 1 from edge 33. `ready_out`=1 throughout.
- 0x5A presented at edge 2, held until accepted → accepted at edge 2, `ready_out`=0. Bits 0,1,0,1,1,0,1,0 appear after edges 33–40. `ready_out`=1 after edge 33. Commas resume after edge 41.
- `valid_in` held high with 0x01, 0x02, 0x03 in ACTIVE → three contiguous words 00000001, 00000010, 00000011 with no comma between them. Each `ready_out` low period ends one cycle after the corresponding load edge.
- 0xBC sent as data, followed by idle → line shows an indistinguishable 0xBC, then comma fill. `active` stays 1.
- `reset_L` pulsed low mid-word 3 of a data byte with `hold_full`=1 → `data_out`, `active` drop to 0 immediately and `ready_out`=1. The held byte is never transmitted. A fresh sync sequence starts, and `active` rises again at edge 33.
- SYNC_WORDS=1 variant → a single comma is sent, and `active` rises on edge 9.

Source files
------------

// File: rtl/phy_pkg.sv
// Constants and types shared by the TX serializer and the RX deserializer so both
// ends of the link agree on the comma word and on the length of the sync preamble.
package phy_pkg;

  localparam logic [7:0] COMMA_WORD     = 8'hBC;
  localparam int         SYNC_WORDS_DEF = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_t;

endpackage

// File: rtl/paralelo_serial_phy_tx_if.sv
// Byte-wide valid/ready handshake into the TX serializer.
// The producer drives data_in/valid_in; the serializer returns ready_out.
interface paralelo_serial_phy_tx_if;

  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;

  modport master (output data_in, output valid_in, input  ready_out);
  modport slave  (input  data_in, input  valid_in, output ready_out);

endinterface

// File: rtl/phy_tx_hold_reg.sv
// Single-entry holding register: captures a byte when empty and valid, and is
// emptied by pop. Zero latency to full; backpressures by refusing input while full.
module phy_tx_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk_32f,
  input  logic         reset_L,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic [W-1:0] data
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // pop is only issued while full, so it never coincides with a push.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (push_vld && !full_q) begin
      full_d = 1'b1;
      data_d = push_dat;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/paralelo_serial_phy_tx.sv
// Byte-to-serial PHY transmitter, MSB first: sends SYNC_WORDS commas after reset, then
// held bytes or comma fill. Accept-to-line latency 1-8 cycles; one byte per 8 cycles.
module paralelo_serial_phy_tx
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_WORD,
  parameter int         SYNC_WORDS = SYNC_WORDS_DEF
) (
  input  logic                      clk_32f,
  input  logic                      reset_L,
  paralelo_serial_phy_tx_if.slave   bus,
  output logic                      data_out,
  output logic                      active
);

  localparam int SCW = $clog2(SYNC_WORDS + 1);
  localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_WORDS);

  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0] sync_cnt_q, sync_cnt_d;
  tx_state_t      state_q, state_d;

  logic       hold_full;
  logic [7:0] hold_data;
  logic       pop;

  phy_tx_hold_reg #(.W(8)) u_hold (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .push_vld (bus.valid_in),
    .push_dat (bus.data_in),
    .pop      (pop),
    .full     (hold_full),
    .data     (hold_data)
  );

  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    sync_cnt_d = sync_cnt_q;
    state_d    = state_q;
    pop        = 1'b0;
    if (bit_cnt_q != 3'd7) begin
      shreg_d = {shreg_q[6:0], 1'b0};
    end else begin
      bit_cnt_d = 3'd0;
      shreg_d   = COMMA;
      if (state_q == SYNC && sync_cnt_q != SYNC_LAST) begin
        sync_cnt_d = sync_cnt_q + SCW'(1);
      end else begin
        // Sync just completed or already active: the held byte goes out on this same boundary.
        state_d = ACTIVE;
        if (hold_full) begin
          shreg_d = hold_data;
          pop     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      shreg_q    <= 8'h00;
      bit_cnt_q  <= 3'd7;
      sync_cnt_q <= '0;
      state_q    <= SYNC;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      state_q    <= state_d;
    end
  end

  assign data_out      = shreg_q[7];
  assign active        = (state_q == ACTIVE);
  assign bus.ready_out = !hold_full;

endmodule

// File: tb/tb_paralelo_serial_phy_tx.sv
// Directed bench for paralelo_serial_phy_tx: sync preamble, handshake, back-to-back
// bytes, comma-valued data, mid-word reset, and a SYNC_WORDS=1 instance.
module tb_paralelo_serial_phy_tx;

  localparam logic [7:0] CW = 8'hBC;

  logic clk;
  logic reset_L;
  logic data_out0, active0, data_out1, active1;
  int   edge_n;
  int   errs;
  int   checks;

  paralelo_serial_phy_tx_if bus0 ();
  paralelo_serial_phy_tx_if bus1 ();

  paralelo_serial_phy_tx #(.COMMA(8'hBC), .SYNC_WORDS(4)) dut0 (
    .clk_32f  (clk),
    .reset_L  (reset_L),
    .bus      (bus0),
    .data_out (data_out0),
    .active   (active0)
  );

  paralelo_serial_phy_tx #(.COMMA(8'hBC), .SYNC_WORDS(1)) dut1 (
    .clk_32f  (clk),
    .reset_L  (reset_L),
    .bus      (bus1),
    .data_out (data_out1),
    .active   (active1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, act, exp);
    end
  endtask

  // Bit of word w that is on the line after edge e (words start at edges 8k+1).
  function automatic logic exp_bit(input logic [7:0] w, input int e);
    logic [7:0] t;
    t = w;
    return t[3'(7 - ((e - 1) % 8))];
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    bus0.valid_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", 32'(data_out0), 32'd0);
    check("rst_rdy", 32'(bus0.ready_out), 32'd1);
    check("rst_active", 32'(active0), 32'd0);
    check("rst_active1", 32'(active1), 32'd0);
    reset_L = 1'b1;
    edge_n  = 0;
  endtask

  logic [7:0] seq [3];
  logic [7:0] w;
  logic       fire;
  logic       rexp;
  int         idx;

  initial begin
    errs = 0;
    checks = 0;
    edge_n = 0;
    reset_L = 1'b0;
    bus0.valid_in = 1'b0;
    bus0.data_in  = 8'h00;
    bus1.valid_in = 1'b0;
    bus1.data_in  = 8'h00;

    // Idle after reset: comma stream, active at 33 (9 for the one-word variant).
    do_reset();
    for (int e = 1; e <= 80; e++) begin
      tick();
      check("t1_data", 32'(data_out0), 32'(exp_bit(CW, edge_n)));
      check("t1_active", 32'(active0), 32'(edge_n >= 33));
      check("t1_rdy", 32'(bus0.ready_out), 32'd1);
      check("t1_data1", 32'(data_out1), 32'(exp_bit(CW, edge_n)));
      check("t1_active1", 32'(active1), 32'(edge_n >= 9));
      check("t1_rdy1", 32'(bus1.ready_out), 32'd1);
    end

    // Byte accepted during sync waits for the first active word.
    do_reset();
    tick();
    bus0.valid_in = 1'b1;
    bus0.data_in  = 8'h5A;
    tick();
    check("t2_rdy_acc", 32'(bus0.ready_out), 32'd0);
    bus0.valid_in = 1'b0;
    while (edge_n < 48) begin
      tick();
      w = (edge_n >= 33 && edge_n <= 40) ? 8'h5A : CW;
      check("t2_data", 32'(data_out0), 32'(exp_bit(w, edge_n)));
      check("t2_rdy", 32'(bus0.ready_out), 32'(edge_n >= 33));
      check("t2_active", 32'(active0), 32'(edge_n >= 33));
    end

    // Back-to-back bytes with valid held high.
    seq[0] = 8'h01;
    seq[1] = 8'h02;
    seq[2] = 8'h03;
    idx = 0;
    while (edge_n < 88) begin
      fire = bus0.valid_in && bus0.ready_out;
      tick();
      if (fire) begin
        idx++;
        if (idx < 3) bus0.data_in = seq[idx];
        else         bus0.valid_in = 1'b0;
      end
      if (edge_n == 50) begin
        bus0.valid_in = 1'b1;
        bus0.data_in  = seq[0];
      end
      if      (edge_n >= 57 && edge_n <= 64) w = 8'h01;
      else if (edge_n >= 65 && edge_n <= 72) w = 8'h02;
      else if (edge_n >= 73 && edge_n <= 80) w = 8'h03;
      else                                   w = CW;
      rexp = (edge_n <= 50) || (edge_n == 57) || (edge_n == 65) || (edge_n >= 73);
      check("t3_data", 32'(data_out0), 32'(exp_bit(w, edge_n)));
      check("t3_rdy", 32'(bus0.ready_out), 32'(rexp));
    end

    // Comma-valued data goes out unchanged and is indistinguishable from fill.
    while (edge_n < 112) begin
      fire = bus0.valid_in && bus0.ready_out;
      tick();
      if (fire) bus0.valid_in = 1'b0;
      if (edge_n == 89) begin
        bus0.valid_in = 1'b1;
        bus0.data_in  = 8'hBC;
      end
      check("t4_data", 32'(data_out0), 32'(exp_bit(CW, edge_n)));
      check("t4_rdy", 32'(bus0.ready_out), 32'(!(edge_n >= 90 && edge_n <= 96)));
      check("t4_active", 32'(active0), 32'd1);
    end

    // Reset mid data word with a second byte held: held byte is dropped.
    do_reset();
    seq[0] = 8'h77;
    seq[1] = 8'h99;
    idx = 0;
    while (edge_n < 44) begin
      fire = bus0.valid_in && bus0.ready_out;
      tick();
      if (fire) begin
        idx++;
        if (idx < 2) bus0.data_in = seq[idx];
        else         bus0.valid_in = 1'b0;
      end
      if (edge_n == 33) begin
        bus0.valid_in = 1'b1;
        bus0.data_in  = seq[0];
      end
    end
    check("t5_pre_data", 32'(data_out0), 32'(exp_bit(8'h77, 44)));
    check("t5_pre_rdy", 32'(bus0.ready_out), 32'd0);
    reset_L = 1'b0;
    #1;
    check("t5_rst_data", 32'(data_out0), 32'd0);
    check("t5_rst_active", 32'(active0), 32'd0);
    check("t5_rst_rdy", 32'(bus0.ready_out), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    edge_n  = 0;
    while (edge_n < 48) begin
      tick();
      check("t5_data", 32'(data_out0), 32'(exp_bit(CW, edge_n)));
      check("t5_active", 32'(active0), 32'(edge_n >= 33));
      check("t5_rdy", 32'(bus0.ready_out), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
